mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 5-stage pipelined MIPS core, directly downstream of the execute stage. Holds the EX/MEM pipeline register, a word-organised data memory with byte/half/word access, and the MEM/WB pipeline register. Drives the write-back mux and returns the MEM-stage and WB-stage destination/result signals to execute for forwarding.

## Interface
Parameters:
- ADDR_W, 8, log2 of data-memory depth in 32-bit words (default 256 words = 1 KiB)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- RegWriteAddr_ex  in  5  destination register from execute
- ALUResult_ex  in  32  ALU result / effective address from execute
- MemWriteData_ex  in  32  forwarded store data from execute
- RegWrite_ex  in  1  instruction writes a register
- MemWrite_ex  in  1  instruction is a store
- MemtoReg_ex  in  1  write-back takes load data (1) or ALU result (0)
- MemWidth_ex  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
- LoadUnsigned_ex  in  1  zero-extend (1) / sign-extend (0) sub-word loads
- ALUResult_mem  out  32  EX/MEM registered ALU result (to execute forwarding)
- RegWriteAddr_mem  out  5  EX/MEM registered destination
- RegWrite_mem  out  1  EX/MEM registered write enable, forced 0 on address error
- AddrErr_mem  out  1  misaligned access in MEM this cycle
- RegWriteData_wb  out  32  write-back data to register file and forwarding
- RegWriteAddr_wb  out  5  MEM/WB registered destination
- RegWrite_wb  out  1  MEM/WB registered write enable

## Operation
- EX/MEM register: on each rising edge captures all *_ex inputs; reset clears every field to 0.
- Word index = ALUResult_mem[ADDR_W+1:2]; address bits above ADDR_W+1 ignored (accesses wrap modulo memory size).
- Lane = ALUResult_mem[1:0]; little-endian: lane 0 = bits 7:0, lane 3 = bits 31:24.
- Alignment: word requires lane==0; half requires lane[0]==0; byte always aligned. Misaligned access with MemWrite or MemtoReg set asserts AddrErr_mem (combinational), suppresses the memory write and forces RegWrite_mem (and thus the captured RegWrite_wb) to 0.
- Stores: synchronous write at the rising edge ending the MEM cycle, only when MemWrite_mem=1, no AddrErr_mem, reset=0. Word writes all lanes; half writes lanes {lane+1,lane} from MemWriteData_mem[15:0]; byte writes one lane from MemWriteData_mem[7:0]. Untouched lanes keep contents.
- Loads: asynchronous read of the addressed word; selected byte/half extended per LoadUnsigned_mem; result captured into MEM/WB.
- MEM/WB register captures load data, ALUResult_mem, RegWriteAddr_mem, RegWrite_mem (after error gating), MemtoReg_mem; reset clears all to 0.
- RegWriteData_wb = MemtoReg_wb ? LoadData_wb : ALUResult_wb (combinational).
- Memory contents are not cleared by reset; simulation initialises to 0.

## Timing
- Latency: EX inputs visible on *_mem outputs one cycle later; on *_wb outputs two cycles later.
- Store followed immediately by load to same word: load in next cycle reads the new value (write committed at the edge between them).
- Reset outputs: ALUResult_mem=0, RegWriteAddr_mem=0, RegWrite_mem=0, AddrErr_mem=0, RegWriteAddr_wb=0, RegWrite_wb=0, RegWriteData_wb=0.
- Reset asserted mid-operation: store in MEM at that edge is not performed; both pipeline registers cleared at the same edge; first post-reset instruction appears on *_mem one cycle after reset deasserts with its inputs.
- No stall or handshake: every cycle advances; bubbles are encoded upstream as RegWrite_ex=0, MemWrite_ex=0.

## Test plan
- Word store/load: sw 0xDEADBEEF to addr 0x10, next cycle lw addr 0x10, dest 5 -> two cycles later RegWriteData_wb=0xDEADBEEF, RegWriteAddr_wb=5, RegWrite_wb=1.
- Byte/half extension: word 0x80FF7F01 at 0x20; lb 0x23 -> 0xFFFFFF80; lbu 0x23 -> 0x00000080; lh 0x22 -> 0xFFFF80FF; lhu 0x20 -> 0x00007F01.
- Sub-word store: word 0x11223344 at 0x30; sb 0xAA to 0x31, then sh 0xBEEF to 0x32 -> lw 0x30 returns 0xBEEFAA44.
- Misalignment: lw at 0x31 with RegWrite_ex=1 -> AddrErr_mem=1, RegWrite_mem=0, RegWrite_wb=0 next cycle; sh at 0x41 -> memory word 0x40 unchanged.
- Wrap and ALU path: sw 0x12345678 to 0x400 (ADDR_W=8) -> lw 0x0 returns 0x12345678; add result 0x7 with MemtoReg=0 -> RegWriteData_wb=0x7.
- Reset mid-store: sw in MEM with reset=1 at the edge -> target word unchanged, all *_mem/*_wb outputs 0 the following cycle.

Source files
------------

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage: memory-access stage of a 5-stage pipelined MIPS core.
//
// Holds the EX/MEM pipeline register, a word-organised little-endian data
// memory supporting byte/half/word loads and stores, and the MEM/WB pipeline
// register. Produces the write-back mux output and returns MEM/WB stage
// destination/result signals to execute for forwarding.
//
// Parameters:
//   ADDR_W            log2 of data-memory depth in 32-bit words
// Ports:
//   clk               rising-edge clock
//   reset             synchronous, active-high reset
//   RegWriteAddr_ex   destination register from execute
//   ALUResult_ex      ALU result / effective address from execute
//   MemWriteData_ex   forwarded store data from execute
//   RegWrite_ex       instruction writes a register
//   MemWrite_ex       instruction is a store
//   MemtoReg_ex       write-back selects load data (1) or ALU result (0)
//   MemWidth_ex       00 word, 01 half, 10 byte, 11 reserved (word)
//   LoadUnsigned_ex   zero-extend (1) / sign-extend (0) sub-word loads
//   ALUResult_mem     EX/MEM registered ALU result
//   RegWriteAddr_mem  EX/MEM registered destination
//   RegWrite_mem      EX/MEM write enable, gated off on address error
//   AddrErr_mem       misaligned memory access in MEM this cycle
//   RegWriteData_wb   write-back data (register file and forwarding)
//   RegWriteAddr_wb   MEM/WB registered destination
//   RegWrite_wb       MEM/WB registered write enable
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  RegWriteAddr_ex,
    input  logic [31:0] ALUResult_ex,
    input  logic [31:0] MemWriteData_ex,
    input  logic        RegWrite_ex,
    input  logic        MemWrite_ex,
    input  logic        MemtoReg_ex,
    input  logic [1:0]  MemWidth_ex,
    input  logic        LoadUnsigned_ex,
    output logic [31:0] ALUResult_mem,
    output logic [4:0]  RegWriteAddr_mem,
    output logic        RegWrite_mem,
    output logic        AddrErr_mem,
    output logic [31:0] RegWriteData_wb,
    output logic [4:0]  RegWriteAddr_wb,
    output logic        RegWrite_wb
);

    localparam logic [1:0] WIDTH_WORD = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_BYTE = 2'b10;

    localparam int DEPTH = 1 << ADDR_W;

    // ---------------- EX/MEM pipeline register ----------------
    logic [31:0] mem_write_data_mem;
    logic        reg_write_raw_mem;
    logic        mem_write_mem;
    logic        memto_reg_mem;
    logic [1:0]  mem_width_mem;
    logic        load_unsigned_mem;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            ALUResult_mem      <= '0;
            RegWriteAddr_mem   <= '0;
            mem_write_data_mem <= '0;
            reg_write_raw_mem  <= 1'b0;
            mem_write_mem      <= 1'b0;
            memto_reg_mem      <= 1'b0;
            mem_width_mem      <= WIDTH_WORD;
            load_unsigned_mem  <= 1'b0;
        end else begin
            ALUResult_mem      <= ALUResult_ex;
            RegWriteAddr_mem   <= RegWriteAddr_ex;
            mem_write_data_mem <= MemWriteData_ex;
            reg_write_raw_mem  <= RegWrite_ex;
            mem_write_mem      <= MemWrite_ex;
            memto_reg_mem      <= MemtoReg_ex;
            mem_width_mem      <= MemWidth_ex;
            load_unsigned_mem  <= LoadUnsigned_ex;
        end
    end

    // ---------------- Address decode and alignment ----------------
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic              misaligned;

    // Upper address bits are dropped, so accesses wrap modulo memory size.
    assign word_idx = ALUResult_mem[ADDR_W+1:2];
    assign lane     = ALUResult_mem[1:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block can infer a latch.
        misaligned = 1'b0;
        case (mem_width_mem)
            WIDTH_HALF: misaligned = lane[0];
            WIDTH_BYTE: misaligned = 1'b0;
            default:    misaligned = (lane != 2'b00);  // word and reserved
        endcase
    end

    // Only memory operations can fault; an ALU result that happens to look
    // misaligned is just data.
    assign AddrErr_mem  = misaligned && (mem_write_mem || memto_reg_mem);
    assign RegWrite_mem = reg_write_raw_mem && !AddrErr_mem;

    // ---------------- Data memory ----------------
    logic [31:0] mem [DEPTH];

    logic [3:0]  byte_en;
    logic [31:0] store_data;

    // Store data is replicated across lanes so the byte enables alone pick
    // which bytes land in the word.
    always_comb begin
        byte_en    = 4'b1111;
        store_data = mem_write_data_mem;
        case (mem_width_mem)
            WIDTH_HALF: begin
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                store_data = {2{mem_write_data_mem[15:0]}};
            end
            WIDTH_BYTE: begin
                byte_en    = 4'b0001 << lane;
                store_data = {4{mem_write_data_mem[7:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                store_data = mem_write_data_mem;
            end
        endcase
    end

    // NOTE: the memory array has no reset branch; clearing a RAM takes
    // DEPTH cycles or a flop-based array, so contents simply survive reset.
    always_ff @(posedge clk) begin
        if (!reset && mem_write_mem && !AddrErr_mem) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
                end
            end
        end
    end

    // Asynchronous read, lane select and extension.
    logic [31:0] rd_word;
    logic [15:0] rd_half;
    logic [7:0]  rd_byte;
    logic [31:0] load_data;

    always_comb begin
        rd_word = mem[word_idx];
        rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (lane)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        case (mem_width_mem)
            WIDTH_HALF: load_data = load_unsigned_mem ? {16'h0000, rd_half}
                                                      : {{16{rd_half[15]}}, rd_half};
            WIDTH_BYTE: load_data = load_unsigned_mem ? {24'h000000, rd_byte}
                                                      : {{24{rd_byte[7]}}, rd_byte};
            default:    load_data = rd_word;
        endcase
    end

    // ---------------- MEM/WB pipeline register ----------------
    logic [31:0] load_data_wb;
    logic [31:0] alu_result_wb;
    logic        memto_reg_wb;

    always_ff @(posedge clk) begin
        if (reset) begin
            load_data_wb    <= '0;
            alu_result_wb   <= '0;
            RegWriteAddr_wb <= '0;
            RegWrite_wb     <= 1'b0;
            memto_reg_wb    <= 1'b0;
        end else begin
            load_data_wb    <= load_data;
            alu_result_wb   <= ALUResult_mem;
            RegWriteAddr_wb <= RegWriteAddr_mem;
            RegWrite_wb     <= RegWrite_mem;
            memto_reg_wb    <= memto_reg_mem;
        end
    end

    assign RegWriteData_wb = memto_reg_wb ? load_data_wb : alu_result_wb;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage: directed self-checking bench for mem_stage.
// Each issue() call presents one instruction and advances one clock, so the
// instruction sits in MEM afterwards and reaches WB after the next issue().
// ---------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic [4:0]  RegWriteAddr_ex;
    logic [31:0] ALUResult_ex;
    logic [31:0] MemWriteData_ex;
    logic        RegWrite_ex;
    logic        MemWrite_ex;
    logic        MemtoReg_ex;
    logic [1:0]  MemWidth_ex;
    logic        LoadUnsigned_ex;
    logic [31:0] ALUResult_mem;
    logic [4:0]  RegWriteAddr_mem;
    logic        RegWrite_mem;
    logic        AddrErr_mem;
    logic [31:0] RegWriteData_wb;
    logic [4:0]  RegWriteAddr_wb;
    logic        RegWrite_wb;

    int checks = 0;
    int errors = 0;

    mem_stage #(.ADDR_W(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .RegWriteAddr_ex  (RegWriteAddr_ex),
        .ALUResult_ex     (ALUResult_ex),
        .MemWriteData_ex  (MemWriteData_ex),
        .RegWrite_ex      (RegWrite_ex),
        .MemWrite_ex      (MemWrite_ex),
        .MemtoReg_ex      (MemtoReg_ex),
        .MemWidth_ex      (MemWidth_ex),
        .LoadUnsigned_ex  (LoadUnsigned_ex),
        .ALUResult_mem    (ALUResult_mem),
        .RegWriteAddr_mem (RegWriteAddr_mem),
        .RegWrite_mem     (RegWrite_mem),
        .AddrErr_mem      (AddrErr_mem),
        .RegWriteData_wb  (RegWriteData_wb),
        .RegWriteAddr_wb  (RegWriteAddr_wb),
        .RegWrite_wb      (RegWrite_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] W = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] B = 2'b10;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one instruction, clock it into MEM, settle 1 ns past the edge.
    task automatic issue(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wdata,
                         input logic rw, input logic mw, input logic m2r,
                         input logic [1:0] width, input logic uns);
        RegWriteAddr_ex = rd;
        ALUResult_ex    = alu;
        MemWriteData_ex = wdata;
        RegWrite_ex     = rw;
        MemWrite_ex     = mw;
        MemtoReg_ex     = m2r;
        MemWidth_ex     = width;
        LoadUnsigned_ex = uns;
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        issue(5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, W, 1'b0);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, " ALUResult_mem"},    ALUResult_mem,           32'h0);
        check({pfx, " RegWriteAddr_mem"}, {27'h0, RegWriteAddr_mem}, 32'h0);
        check({pfx, " RegWrite_mem"},     {31'h0, RegWrite_mem},   32'h0);
        check({pfx, " AddrErr_mem"},      {31'h0, AddrErr_mem},    32'h0);
        check({pfx, " RegWriteAddr_wb"},  {27'h0, RegWriteAddr_wb},  32'h0);
        check({pfx, " RegWrite_wb"},      {31'h0, RegWrite_wb},    32'h0);
        check({pfx, " RegWriteData_wb"},  RegWriteData_wb,         32'h0);
    endtask

    initial begin
        // Reset with junk on the inputs: registers must still clear.
        reset = 1'b1;
        issue(5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, W, 1'b1);
        issue(5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, W, 1'b1);
        check_all_zero("reset");
        reset = 1'b0;

        // Word store then load of the same word on the next cycle.
        issue(5'd0, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, W, 1'b0);
        check("sw ALUResult_mem", ALUResult_mem, 32'h10);
        check("sw RegWrite_mem", {31'h0, RegWrite_mem}, 32'h0);
        issue(5'd5, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, W, 1'b0);
        check("lw RegWrite_mem", {31'h0, RegWrite_mem}, 32'h1);
        check("lw RegWriteAddr_mem", {27'h0, RegWriteAddr_mem}, 32'd5);
        nop();
        check("lw data", RegWriteData_wb, 32'hDEAD_BEEF);
        check("lw RegWriteAddr_wb", {27'h0, RegWriteAddr_wb}, 32'd5);
        check("lw RegWrite_wb", {31'h0, RegWrite_wb}, 32'h1);

        // Sub-word load extension from 0x80FF7F01.
        issue(5'd0, 32'h20, 32'h80FF_7F01, 1'b0, 1'b1, 1'b0, W, 1'b0);
        issue(5'd1, 32'h23, 32'h0, 1'b1, 1'b0, 1'b1, B, 1'b0);   // lb
        check("lb odd lane AddrErr", {31'h0, AddrErr_mem}, 32'h0);
        issue(5'd2, 32'h23, 32'h0, 1'b1, 1'b0, 1'b1, B, 1'b1);   // lbu
        check("lb data", RegWriteData_wb, 32'hFFFF_FF80);
        issue(5'd3, 32'h22, 32'h0, 1'b1, 1'b0, 1'b1, H, 1'b0);   // lh
        check("lbu data", RegWriteData_wb, 32'h0000_0080);
        issue(5'd4, 32'h20, 32'h0, 1'b1, 1'b0, 1'b1, H, 1'b1);   // lhu
        check("lh data", RegWriteData_wb, 32'hFFFF_80FF);
        nop();
        check("lhu data", RegWriteData_wb, 32'h0000_7F01);
        check("lhu RegWriteAddr_wb", {27'h0, RegWriteAddr_wb}, 32'd4);

        // Sub-word stores merge into an existing word; upper data bits ignored.
        issue(5'd0, 32'h30, 32'h1122_3344, 1'b0, 1'b1, 1'b0, W, 1'b0);
        issue(5'd0, 32'h31, 32'h1234_56AA, 1'b0, 1'b1, 1'b0, B, 1'b0);
        issue(5'd0, 32'h32, 32'hCAFE_BEEF, 1'b0, 1'b1, 1'b0, H, 1'b0);
        issue(5'd6, 32'h30, 32'h0, 1'b1, 1'b0, 1'b1, W, 1'b0);
        nop();
        check("sb/sh merge", RegWriteData_wb, 32'hBEEF_AA44);

        // Misaligned word load: error raised, write-back suppressed.
        issue(5'd7, 32'h31, 32'h0, 1'b1, 1'b0, 1'b1, W, 1'b0);
        check("mis lw AddrErr_mem", {31'h0, AddrErr_mem}, 32'h1);
        check("mis lw RegWrite_mem", {31'h0, RegWrite_mem}, 32'h0);
        nop();
        check("mis lw RegWrite_wb", {31'h0, RegWrite_wb}, 32'h0);

        // Misaligned half store must leave memory untouched.
        issue(5'd0, 32'h40, 32'h5566_7788, 1'b0, 1'b1, 1'b0, W, 1'b0);
        issue(5'd0, 32'h41, 32'h0000_FFFF, 1'b0, 1'b1, 1'b0, H, 1'b0);
        check("mis sh AddrErr_mem", {31'h0, AddrErr_mem}, 32'h1);
        issue(5'd8, 32'h40, 32'h0, 1'b1, 1'b0, 1'b1, W, 1'b0);
        nop();
        check("mis sh word intact", RegWriteData_wb, 32'h5566_7788);

        // Address wrap: 0x400 aliases word 0 with 256 words.
        issue(5'd0, 32'h400, 32'h1234_5678, 1'b0, 1'b1, 1'b0, W, 1'b0);
        issue(5'd10, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, W, 1'b0);
        nop();
        check("wrap lw data", RegWriteData_wb, 32'h1234_5678);

        // ALU result path; low bits 11 are not an error without a memory op.
        issue(5'd9, 32'h7, 32'h0, 1'b1, 1'b0, 1'b0, W, 1'b0);
        check("alu AddrErr_mem", {31'h0, AddrErr_mem}, 32'h0);
        check("alu RegWrite_mem", {31'h0, RegWrite_mem}, 32'h1);
        nop();
        check("alu data", RegWriteData_wb, 32'h0000_0007);
        check("alu RegWriteAddr_wb", {27'h0, RegWriteAddr_wb}, 32'd9);

        // Reset while a store sits in MEM.
        issue(5'd0, 32'h50, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0, W, 1'b0);
        issue(5'd11, 32'h50, 32'h0, 1'b1, 1'b0, 1'b1, W, 1'b0);
        issue(5'd0, 32'h50, 32'hA5A5_A5A5, 1'b0, 1'b1, 1'b0, W, 1'b0);
        check("pre-reset wb data", RegWriteData_wb, 32'h0BAD_F00D);
        reset = 1'b1;
        nop();
        check_all_zero("mid reset");
        reset = 1'b0;
        issue(5'd12, 32'h50, 32'h0, 1'b1, 1'b0, 1'b1, W, 1'b0);
        check("post-reset RegWriteAddr_mem", {27'h0, RegWriteAddr_mem}, 32'd12);
        check("post-reset RegWrite_mem", {31'h0, RegWrite_mem}, 32'h1);
        nop();
        check("reset store dropped", RegWriteData_wb, 32'h0BAD_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
